// File: rtl/vec_rmw_sweeper.sv
// Read-modify-write sweep engine: reads 8-lane vectors from the image buffer, streams
// them through an external processing stage and writes the results back in place.

module vec_rmw_lane #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_cap_src,
  input  logic         i_cap_res,
  input  logic         i_clr_wd,
  input  logic [W-1:0] i_rd,
  input  logic [W-1:0] i_res,
  output logic [W-1:0] o_src,
  output logic [W-1:0] o_wd
);
  logic [W-1:0] r_src, r_wd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src <= '0;
      r_wd  <= '0;
    end else begin
      if (i_cap_src) r_src <= i_rd;
      if (i_cap_res)     r_wd <= i_res;
      else if (i_clr_wd) r_wd <= '0;
    end
  end

  assign o_src = r_src;
  assign o_wd  = r_wd;
endmodule

module vec_rmw_sweeper #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 320,
  parameter int PIX_SIZE     = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  input  logic [19:0]              base,
  input  logic [14:0]              vec_count,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [19:0]              mem_addr,
  output logic                     mem_we,
  output logic [7:0][PIX_SIZE-1:0] mem_wd,
  input  logic [7:0][PIX_SIZE-1:0] mem_rd,
  output logic                     src_valid,
  output logic [7:0][PIX_SIZE-1:0] src_data,
  input  logic                     src_ready,
  input  logic                     res_valid,
  input  logic [7:0][PIX_SIZE-1:0] res_data,
  output logic                     res_ready
);
  localparam int          NUM_LANES = 8;
  localparam logic [31:0] IMG_BYTES = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_RECV, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [19:0] r_cur, r_addr;
  logic [14:0] r_rem;
  logic        r_busy, r_done, r_err, r_we, r_src_valid, r_res_ready;

  logic [19:0] w_base_al, w_next;
  logic [31:0] w_end;
  logic        w_cap_src, w_cap_res, w_clr_wd;
  logic        w_unused;

  assign w_base_al = {base[19:6], 6'b0};
  assign w_end     = {12'b0, w_base_al} + {14'b0, vec_count, 3'b0};
  assign w_unused  = ^base[5:0];
  // Lanes interleave at stride 8, so offsets 0..7 share a block; offset 7 jumps to the next block.
  assign w_next    = (r_cur[2:0] != 3'd7) ? r_cur + 20'd1 : r_cur + 20'd57;

  assign w_cap_src = (r_state == S_READ);
  assign w_cap_res = (r_state == S_RECV) && res_valid;
  assign w_clr_wd  = (r_state == S_WRITE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_src_valid <= 1'b0;
      r_res_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_busy <= 1'b1;
          if (vec_count == 15'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_end > IMG_BYTES) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cur   <= w_base_al;
            r_addr  <= w_base_al;
            r_rem   <= vec_count;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_src_valid <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: if (src_ready) begin
          r_src_valid <= 1'b0;
          r_res_ready <= 1'b1;
          r_state     <= S_RECV;
        end
        S_RECV: if (res_valid) begin
          r_res_ready <= 1'b0;
          r_we        <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_we  <= 1'b0;
          r_rem <= r_rem - 15'd1;
          if (r_rem == 15'd1) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cur   <= w_next;
            r_addr  <= w_next;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vec_rmw_lane #(.W(PIX_SIZE)) u_lane (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .i_cap_src (w_cap_src),
      .i_cap_res (w_cap_res),
      .i_clr_wd  (w_clr_wd),
      .i_rd      (mem_rd[g]),
      .i_res     (res_data[g]),
      .o_src     (src_data[g]),
      .o_wd      (mem_wd[g])
    );
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign src_valid = r_src_valid;
  assign res_ready = r_res_ready;
endmodule
